demux_stream: RTL

- Parametrised, registered 1:N stream demultiplexer; next generation of the combinational 1:8 demux.
- Routes each accepted input beat to the output channel chosen by in_sel.
- Uses a valid/ready handshake on the input and on every output channel.
- Each output channel has one holding slot. Out-of-range selects are dropped and counted.
- Sits between a single producer and N independent consumers.

---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_slot.sv | 58 +++++
 rtl/demux_stream.sv | 109 ++++++++++
 3 files changed

// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the demux_stream channel demultiplexer.
package demux_stream_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DROP_W_DEFAULT = 8;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single holding register with its EMPTY/FULL state machine.
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      state_r;
    slot_state_e      state_s;
    logic [WIDTH-1:0] data_r;

    // Next-state decode; a load while full only happens alongside a pop, so FULL persists.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (load) begin
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (pop_ready && !load) begin
                    state_s = EMPTY;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = EMPTY;
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (load) begin
                data_r <= load_data;
            end
        end
    end

    assign valid = (state_r == FULL);
    assign data  = data_r;

endmodule

// File: rtl/demux_stream.sv
// Registered 1:N stream demultiplexer with per-channel holding slots and a drop counter.
// Optional round-robin destination selection is enabled by defining DEMUX_STREAM_AUTO_SEL_EN.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int DROP_W = DROP_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
`ifdef DEMUX_STREAM_AUTO_SEL_EN
    input  logic                   auto_mode,
`endif
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   drop_pulse
);

    logic [SEL_W-1:0] sel_s;
    logic             in_range_s;
    logic             ready_sel_s;
    logic [N_OUT-1:0] load_s;
    logic             drop_s;

`ifdef DEMUX_STREAM_AUTO_SEL_EN
    logic [SEL_W-1:0] rr_ptr_r;

    // Destination comes from the round-robin pointer in auto mode, else from in_sel.
    always_comb begin
        if (auto_mode) begin
            sel_s = rr_ptr_r;
        end else begin
            sel_s = in_sel;
        end
    end

    // Pointer advances only on beats accepted in auto mode, wrapping at the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {SEL_W{1'b0}};
        end else if (auto_mode && in_valid && in_ready) begin
            if (rr_ptr_r == SEL_W'(N_OUT - 1)) begin
                rr_ptr_r <= {SEL_W{1'b0}};
            end else begin
                rr_ptr_r <= rr_ptr_r + SEL_W'(1);
            end
        end
    end
`else
    assign sel_s = in_sel;
`endif

    // Select decode, in_ready mux and per-channel load strobes.
    always_comb begin
        in_range_s  = sel_in_range(32'(sel_s), 32'(N_OUT));
        ready_sel_s = 1'b0;
        load_s      = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_s == SEL_W'(k)) begin
                ready_sel_s = !out_valid[k] || out_ready[k];
                load_s[k]   = in_valid && ready_sel_s;
            end else begin
                load_s[k]   = 1'b0;
            end
        end
        if (in_range_s) begin
            in_ready = ready_sel_s;
        end else begin
            in_ready = 1'b1;
        end
        drop_s = in_valid && !in_range_s;
    end

    // Saturating drop counter and its one-cycle indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= {DROP_W{1'b0}};
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop_s;
            if (drop_s && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_s[k]),
            .load_data(in_data),
            .pop_ready(out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule
